irq_ctrl_mem: RTL and testbench

IRQ_CTRL_MEM -- requirements
Module: irq_ctrl_mem

---
 rtl/irq_ctrl_mem_if.sv | 25 ++
 rtl/irq_ctrl_mem.sv | 141 ++++++++++++++
 tb/tb_irq_ctrl_mem.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_mem_if.sv
// Register bus between a CPU-side master and the interrupt controller.
// Enable/ready handshake: request held until ready, enable dropped before next command.
interface irq_ctrl_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    enable;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    bus_err;

    modport master (
        output enable, wr_en, addr, i_data, be,
        input  ready, o_data, bus_err
    );

    modport slave (
        input  enable, wr_en, addr, i_data, be,
        output ready, o_data, bus_err
    );
endinterface

// File: rtl/irq_ctrl_mem.sv
// Interrupt controller with PENDING/MASK/CLEAR/EDGE/ACTIVE registers; IRQC_SYNC_EN adds a 2-flop irq_in synchronizer.
// Latency: ready one edge after enable sampled; irq_in->irq 2 cycles (4 with IRQC_SYNC_EN).
// Backpressure: ready/o_data/bus_err held until the master drops enable; no stalls otherwise.
module irq_ctrl_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_SRC      = 8
) (
    input  logic             clk,
    input  logic             rst,
    irq_ctrl_mem_if.slave    bus,
    input  logic [N_SRC-1:0] irq_in,
    output logic             irq
);
    typedef enum logic {IDLE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] A_PEND  = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] A_MASK  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] A_CLEAR = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] A_EDGE  = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] A_ACT   = ADDR_WIDTH'(8'h10);

    state_t           state;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_sel;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] smp;
    logic [N_SRC-1:0] set_v;
    logic [N_SRC-1:0] clr_v;
    logic [N_SRC-1:0] pm;
    logic [N_SRC-1:0] wdat;
    logic [2:0]       act_idx;
    logic             act_vld;
    logic             sel_pend, sel_mask, sel_clr, sel_edge, sel_act;
    logic             acc_err;
    logic             wr_ok;
    logic [7:0]       rd_byte;
    logic             unused_bits;

    assign unused_bits = ^{bus.i_data, bus.be};

`ifdef IRQC_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign smp = sync2;
`else
    assign smp = irq_in;
`endif

    assign sel_pend = (bus.addr == A_PEND);
    assign sel_mask = (bus.addr == A_MASK);
    assign sel_clr  = (bus.addr == A_CLEAR);
    assign sel_edge = (bus.addr == A_EDGE);
    assign sel_act  = (bus.addr == A_ACT);
    assign wdat     = bus.i_data[N_SRC-1:0];

    assign acc_err = !(sel_pend || sel_mask || sel_clr || sel_edge || sel_act)
                   || !bus.be[0]
                   || (bus.wr_en && (sel_pend || sel_act));
    assign wr_ok   = (state == IDLE) && bus.enable && bus.wr_en && !acc_err;

    assign pm      = pending & mask;
    assign act_vld = |pm;

    always_comb begin
        act_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pm[i]) act_idx = 3'(i);
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (!acc_err) begin
            if (sel_pend)      rd_byte = 8'(pending);
            else if (sel_mask) rd_byte = 8'(mask);
            else if (sel_edge) rd_byte = 8'(edge_sel);
            else if (sel_act)  rd_byte = {act_vld, 4'b0000, act_idx};
        end
    end

    // An edge source only fires when the previous sample was low; level sources fire every cycle.
    assign set_v = smp & ~(edge_sel & prev);
    assign clr_v = (wr_ok && sel_clr) ? wdat : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            prev    <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~clr_v) | set_v;
            prev    <= smp;
            irq     <= |pm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.ready   <= 1'b0;
            bus.o_data  <= '0;
            bus.bus_err <= 1'b0;
            mask        <= '0;
            edge_sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        bus.ready   <= 1'b1;
                        bus.bus_err <= acc_err;
                        bus.o_data  <= DATA_WIDTH'(rd_byte);
                        if (wr_ok && sel_mask) mask     <= wdat;
                        if (wr_ok && sel_edge) edge_sel <= wdat;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.enable) begin
                        bus.ready   <= 1'b0;
                        bus.bus_err <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl_mem.sv
// Randomized scoreboard bench for irq_ctrl_mem against a per-cycle behavioural model.
module tb_irq_ctrl_mem;
`ifdef IRQC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       irq;

    irq_ctrl_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    irq_ctrl_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_SRC(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .irq_in (irq_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    bit   rand_src = 0;
    logic rdy_q = 1'b0;

    logic [7:0] m_pend, m_mask, m_edge, m_prev, m_s1, m_s2;
    bit         m_busy, m_irq;
    logic [7:0] rv;
    logic       re;
    logic [31:0] amap[8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h14, 32'h02};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] active_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 8'h80 | 8'(i);
        end
        return 8'h00;
    endfunction

    // Effect of the coming rising edge on the model, from the inputs currently driven.
    task automatic model_edge();
        logic [7:0] s, set, clr, rd, nmask, nedge;
        logic       err, irq_nx, wm, we;
        if (rst) begin
            m_pend = 0; m_mask = 0; m_edge = 0; m_prev = 0;
            m_s1 = 0; m_s2 = 0; m_busy = 0; m_irq = 0;
            return;
        end
        irq_nx = |(m_pend & m_mask);
`ifdef IRQC_SYNC_EN
        s = m_s2; m_s2 = m_s1; m_s1 = irq_in;
`else
        s = irq_in;
`endif
        clr = 0; wm = 0; we = 0; nmask = 0; nedge = 0;
        if (bus_if.enable && !m_busy) begin
            m_busy = 1;
            err = 0; rd = 0;
            case (bus_if.addr)
                32'h00:  begin err = bus_if.wr_en; rd = m_pend; end
                32'h04:  rd = m_mask;
                32'h08:  rd = 0;
                32'h0C:  rd = m_edge;
                32'h10:  begin err = bus_if.wr_en; rd = active_of(m_pend & m_mask); end
                default: err = 1;
            endcase
            if (!bus_if.be[0]) err = 1;
            if (err) rd = 0;
            exp_q.push_back('{rd, err});
            if (!err && bus_if.wr_en) begin
                if (bus_if.addr == 32'h04) begin wm = 1; nmask = bus_if.i_data[7:0]; end
                if (bus_if.addr == 32'h08) clr = bus_if.i_data[7:0];
                if (bus_if.addr == 32'h0C) begin we = 1; nedge = bus_if.i_data[7:0]; end
            end
        end else if (!bus_if.enable) begin
            m_busy = 0;
        end
        for (int i = 0; i < 8; i++) set[i] = m_edge[i] ? (s[i] && !m_prev[i]) : s[i];
        m_pend = (m_pend & ~clr) | set;
        m_prev = s;
        if (wm) m_mask = nmask;
        if (we) m_edge = nedge;
        m_irq = irq_nx;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        if (rand_src && $urandom_range(0, 3) == 0) irq_in = 8'($urandom);
    endtask

    task automatic bus(input bit wr, input logic [31:0] a, input logic [7:0] d,
                       input logic [3:0] b, output logic [7:0] rd, output logic er);
        bus_if.enable = 1'b1;
        bus_if.wr_en  = wr;
        bus_if.addr   = a;
        bus_if.i_data = {24'($urandom), d};
        bus_if.be     = b;
        tick();
        check("ready_latency", {31'b0, bus_if.ready}, 32'd1);
        rd = bus_if.o_data[7:0];
        er = bus_if.bus_err;
        repeat ($urandom_range(0, 2)) tick();
        bus_if.enable = 1'b0;
        tick();
        check("ready_drop", {31'b0, bus_if.ready}, 32'd0);
        check("err_drop", {31'b0, bus_if.bus_err}, 32'd0);
        repeat ($urandom_range(0, 1)) tick();
    endtask

    // Monitor: every new ready is matched against the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.ready && !rdy_q) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ready: got ready=1, expected no response at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", bus_if.o_data, {24'b0, e.data});
                check("rd_err", {31'b0, bus_if.bus_err}, {31'b0, e.err});
            end
        end
        rdy_q = bus_if.ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end before 500000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        irq_in = 8'h00;
        bus_if.enable = 1'b0;
        bus_if.wr_en  = 1'b0;
        bus_if.addr   = '0;
        bus_if.i_data = '0;
        bus_if.be     = '0;
        tick();
        tick();
        check("rst_ready", {31'b0, bus_if.ready}, 32'd0);
        check("rst_err", {31'b0, bus_if.bus_err}, 32'd0);
        check("rst_odata", bus_if.o_data, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        tick();

        // Mask write/readback
        bus(1, 32'h04, 8'h01, 4'hF, rv, re);
        bus(0, 32'h04, 8'h00, 4'hF, rv, re);
        check("mask_rd", {24'b0, rv}, 32'h01);
        check("mask_err", {31'b0, re}, 32'd0);

        // Level source: latency, set beats clear, clear after drop
        irq_in = 8'h01;
        repeat (LAT - 1) tick();
        check("irq_before_lat", {31'b0, irq}, 32'd0);
        tick();
        check("irq_at_lat", {31'b0, irq}, 32'd1);
        bus(1, 32'h08, 8'h01, 4'h1, rv, re);
        bus(0, 32'h00, 8'h00, 4'h1, rv, re);
        check("level_set_beats_clr", {24'b0, rv}, 32'h01);
        irq_in = 8'h00;
        repeat (LAT + 1) tick();
        bus(1, 32'h08, 8'h01, 4'h1, rv, re);
        bus(0, 32'h00, 8'h00, 4'h1, rv, re);
        check("level_cleared", {24'b0, rv}, 32'h00);
        check("irq_after_clr", {31'b0, irq}, 32'd0);

        // Edge source: one set per rising edge
        bus(1, 32'h0C, 8'h02, 4'h1, rv, re);
        bus(1, 32'h04, 8'h02, 4'h1, rv, re);
        irq_in = 8'h02;
        repeat (10) tick();
        bus(0, 32'h00, 8'h00, 4'h1, rv, re);
        check("edge_set", {24'b0, rv}, 32'h02);
        bus(1, 32'h08, 8'h02, 4'h1, rv, re);
        bus(0, 32'h00, 8'h00, 4'h1, rv, re);
        check("edge_no_reset", {24'b0, rv}, 32'h00);
        irq_in = 8'h00;
        tick();
        irq_in = 8'h02;
        repeat (LAT + 1) tick();
        bus(0, 32'h00, 8'h00, 4'h1, rv, re);
        check("edge_reset", {24'b0, rv}, 32'h02);

        // ACTIVE priority
        irq_in = 8'h00;
        bus(1, 32'h0C, 8'h00, 4'h1, rv, re);
        repeat (LAT + 1) tick();
        bus(1, 32'h08, 8'hFF, 4'h1, rv, re);
        irq_in = 8'h06;
        tick();
        irq_in = 8'h00;
        repeat (LAT + 1) tick();
        bus(1, 32'h04, 8'h04, 4'h1, rv, re);
        bus(0, 32'h10, 8'h00, 4'h1, rv, re);
        check("active_hi", {24'b0, rv}, 32'h82);
        bus(1, 32'h04, 8'h06, 4'h1, rv, re);
        bus(0, 32'h10, 8'h00, 4'h1, rv, re);
        check("active_lo", {24'b0, rv}, 32'h81);

        // Bus errors leave registers alone
        bus(0, 32'h20, 8'h00, 4'h1, rv, re);
        check("err_bad_addr", {31'b0, re}, 32'd1);
        check("err_bad_addr_data", {24'b0, rv}, 32'h00);
        bus(1, 32'h00, 8'hFF, 4'h1, rv, re);
        check("err_wr_pend", {31'b0, re}, 32'd1);
        bus(1, 32'h04, 8'h01, 4'b0010, rv, re);
        check("err_be", {31'b0, re}, 32'd1);
        bus(0, 32'h04, 8'h00, 4'h1, rv, re);
        check("err_mask_kept", {24'b0, rv}, 32'h06);

        // Random traffic
        rand_src = 1;
        for (int n = 0; n < 250; n++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 7) == 0) ? (4'($urandom) & 4'b1110) : (4'($urandom) | 4'b0001);
            bus(1'($urandom), amap[$urandom_range(0, 7)], 8'($urandom), b, rv, re);
        end
        rand_src = 0;

        // Reset in the middle of a transaction, enable held through reset
        irq_in = 8'hFF;
        bus(1, 32'h04, 8'hFF, 4'h1, rv, re);
        repeat (LAT + 1) tick();
        check("irq_pre_rst", {31'b0, irq}, 32'd1);
        bus_if.enable = 1'b1;
        bus_if.wr_en  = 1'b0;
        bus_if.addr   = 32'h04;
        bus_if.be     = 4'h1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ready", {31'b0, bus_if.ready}, 32'd0);
        check("rst_mid_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'b0, bus_if.ready}, 32'd1);
        check("post_rst_mask", bus_if.o_data, 32'd0);
        bus_if.enable = 1'b0;
        repeat (3) tick();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
